// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants, state encodings and display payload for the 4-digit
// 7-segment scanner.
package seg7_scan_mux_pkg;

    localparam int unsigned NDIG  = 4;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned VAL_W = NDIG * NIB_W;
    localparam int unsigned DIG_W = 2;

    localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

    // Display state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] LIT   = 2'd2;

    // One displayable frame: value, decimal points, leading-zero blank enable
    typedef struct packed {
        logic [VAL_W-1:0] val;
        logic [NDIG-1:0]  dp;
        logic             lzb;
    } disp_cfg_t;

    // Digit dig is dark when leading-zero blanking is on and it and every
    // more-significant nibble are zero; digit 0 always shows.
    function automatic logic digit_blanked(input logic [VAL_W-1:0] val,
                                           input logic             lzb,
                                           input logic [DIG_W-1:0] dig);
        logic blank;
        blank = lzb && (dig != 2'd0);
        for (int i = 1; i < 4; i++) begin
            if ((DIG_W'(i) >= dig) && (val[NIB_W*i +: NIB_W] != 4'h0)) begin
                blank = 1'b0;
            end
        end
        return blank;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Slot prescaler: counts 0..PRESCALE-1 and wraps.
//   clk, rst        clock, synchronous active-high reset
//   wrap_c          high in the last cycle of a slot (counter wraps next edge)
//   in_blank_nxt_c  counter value after the next edge is inside the blank window
module seg7_prescaler #(
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic clk,
    input  logic rst,
    output logic wrap_c,
    output logic in_blank_nxt_c
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next count and slot flags
    always_comb begin
        wrap_c         = (cnt == CNT_W'(PRESCALE - 1));
        cnt_nxt        = wrap_c ? '0 : cnt + CNT_W'(1);
        in_blank_nxt_c = (cnt_nxt < CNT_W'(BLANK_CYC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
//   clk, rst   clock, synchronous active-high reset
//   value_i    16-bit hex value (digit 0 = value_i[3:0])
//   dp_i       decimal-point enables per digit
//   lzb_i      blank leading zero digits
//   load_i     capture value_i/dp_i/lzb_i into pending regs
//   upd_o      pulse when pending regs reach the display regs
//   nib_o      nibble of the scanned digit (to the external decoder)
//   an_o       active-low anode enables
//   dp_o       active-low decimal point
//   dig_o      index of the scanned digit
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value_i,
    input  logic [NDIG-1:0]  dp_i,
    input  logic             lzb_i,
    input  logic             load_i,
    output logic             upd_o,
    output logic [NIB_W-1:0] nib_o,
    output logic [NDIG-1:0]  an_o,
    output logic             dp_o,
    output logic [DIG_W-1:0] dig_o
);

    logic             wrap_c;
    logic             in_blank_nxt_c;
    logic             boundary_c;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    disp_cfg_t        disp;
    disp_cfg_t        disp_nxt;
    disp_cfg_t        pend;
    disp_cfg_t        pend_nxt;
    logic             pend_vld;
    logic             pend_vld_nxt;
    logic             lit_nxt;
    logic             upd_nxt;
    logic             dp_nxt;
    logic [DIG_W-1:0] dig_nxt;
    logic [NDIG-1:0]  an_nxt;
    logic [NIB_W-1:0] nib_nxt;

    seg7_prescaler #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk            (clk),
        .rst            (rst),
        .wrap_c         (wrap_c),
        .in_blank_nxt_c (in_blank_nxt_c)
    );

    // Next-state and next-output logic. Outputs are registered from the
    // post-edge values so they stay aligned with the counter and dig_o.
    always_comb begin
        state_nxt    = state;
        disp_nxt     = disp;
        pend_nxt     = pend;
        pend_vld_nxt = pend_vld;
        upd_nxt      = 1'b0;
        boundary_c   = wrap_c && (dig_o == 2'd3);
        dig_nxt      = wrap_c ? dig_o + 2'd1 : dig_o;

        // Commit pending data at the frame boundary first, so a load in the
        // same cycle is held back for the following frame.
        if (boundary_c && pend_vld) begin
            disp_nxt     = pend;
            pend_vld_nxt = 1'b0;
            upd_nxt      = 1'b1;
        end
        if (load_i) begin
            pend_nxt     = '{val: value_i, dp: dp_i, lzb: lzb_i};
            pend_vld_nxt = 1'b1;
        end

        case (state)
            IDLE:    state_nxt = in_blank_nxt_c ? BLANK : LIT;
            BLANK:   state_nxt = in_blank_nxt_c ? BLANK : LIT;
            LIT:     state_nxt = (wrap_c && in_blank_nxt_c) ? BLANK : LIT;
            default: state_nxt = IDLE;
        endcase

        lit_nxt = (state_nxt == LIT) && !digit_blanked(disp_nxt.val, disp_nxt.lzb, dig_nxt);
        an_nxt  = lit_nxt ? ~(NDIG'(1) << dig_nxt) : AN_OFF;
        dp_nxt  = lit_nxt ? ~disp_nxt.dp[dig_nxt] : 1'b1;
        nib_nxt = disp_nxt.val[{dig_nxt, 2'b00} +: NIB_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            disp     <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            dig_o    <= '0;
            upd_o    <= 1'b0;
            an_o     <= AN_OFF;
            dp_o     <= 1'b1;
            nib_o    <= '0;
        end else begin
            state    <= state_nxt;
            disp     <= disp_nxt;
            pend     <= pend_nxt;
            pend_vld <= pend_vld_nxt;
            dig_o    <= dig_nxt;
            upd_o    <= upd_nxt;
            an_o     <= an_nxt;
            dp_o     <= dp_nxt;
            nib_o    <= nib_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (PRESCALE=8, BLANK_CYC=2).
// The reference model tracks elapsed cycles since reset and derives slot,
// digit and blanking arithmetically; loads/frame commits are tracked as
// pending/display values.
module tb_seg7_scan_mux;

    localparam int unsigned P     = 8;
    localparam int unsigned B     = 2;
    localparam int unsigned FRAME = 4 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0;
    logic        lzb_i = 1'b0;
    logic        load_i = 1'b0;
    logic        upd_o;
    logic [3:0]  nib_o;
    logic [3:0]  an_o;
    logic        dp_o;
    logic [1:0]  dig_o;
    logic [11:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          k = 0;
    logic [15:0] m_val = '0;
    logic [15:0] m_pval = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_pdp = '0;
    logic        m_lzb = 1'b0;
    logic        m_plzb = 1'b0;
    logic        m_pvld = 1'b0;
    logic        m_upd = 1'b0;

    seg7_scan_mux #(.PRESCALE(P), .BLANK_CYC(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .value_i (value_i),
        .dp_i    (dp_i),
        .lzb_i   (lzb_i),
        .load_i  (load_i),
        .upd_o   (upd_o),
        .nib_o   (nib_o),
        .an_o    (an_o),
        .dp_o    (dp_o),
        .dig_o   (dig_o)
    );

    always #5 clk = ~clk;

    assign obs = {an_o, dp_o, nib_o, dig_o, upd_o};

    always @(posedge clk) begin
        if (rst) begin
            k = 0; m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0;
            m_lzb = 1'b0; m_plzb = 1'b0; m_pvld = 1'b0; m_upd = 1'b0;
        end else begin
            k = k + 1;
            m_upd = 1'b0;
            if ((k % FRAME) == 0 && m_pvld) begin
                m_val = m_pval; m_dp = m_pdp; m_lzb = m_plzb;
                m_pvld = 1'b0; m_upd = 1'b1;
            end
            if (load_i) begin
                m_pval = value_i; m_pdp = dp_i; m_plzb = lzb_i; m_pvld = 1'b1;
            end
        end
    end

    function automatic logic [11:0] expect_obs();
        int          cnt;
        int          dig;
        logic        lit;
        logic [15:0] upper;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        dp;
        cnt   = k % P;
        dig   = (k / P) % 4;
        upper = m_val >> (4 * dig);
        nib   = upper[3:0];
        lit   = (cnt >= B) && !(m_lzb && dig != 0 && upper == 16'h0);
        an    = lit ? (4'hF ^ 4'(1 << dig)) : 4'hF;
        dp    = lit ? ~m_dp[dig] : 1'b1;
        return {an, dp, nib, 2'(dig), m_upd};
    endfunction

    task automatic test_reset();
        rst = 1'b1; load_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({an_o, dp_o, dig_o, upd_o} !== {4'hF, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got %b want %b", {an_o, dp_o, dig_o, upd_o}, {4'hF, 1'b1, 2'd0, 1'b0});
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expect_obs()) begin
                errors++;
                $display("FAIL reset_scan k=%0d got %h want %h", k, obs, expect_obs());
            end
            if (k == 2) begin
                checks++;
                if (an_o !== 4'hE) begin
                    errors++;
                    $display("FAIL first_lit an_o got %b want 1110", an_o);
                end
            end
        end
    endtask

    task automatic test_load_mid();
        logic [3:0] exp_nib [4];
        logic [3:0] exp_an  [4];
        int upd_cnt = 0;
        int s;
        logic seen = 1'b0;
        logic done = 1'b0;
        exp_nib = '{4'hF, 4'h2, 4'hA, 4'h1};
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int g = 0; g < 64 && (k % FRAME) != 10; g++) @(negedge clk);
        value_i = 16'h1A2F; dp_i = 4'h0; lzb_i = 1'b0;
        for (int i = 0; i < 70; i++) begin
            load_i = (i == 0);
            @(negedge clk);
            checks++;
            if (obs !== expect_obs()) begin
                errors++;
                $display("FAIL load_mid k=%0d got %h want %h", k, obs, expect_obs());
            end
            if (upd_o === 1'b1) begin upd_cnt++; seen = 1'b1; end
            if (seen && !done && (k % P) == B) begin
                s = (k / P) % 4;
                checks++;
                if (nib_o !== exp_nib[s] || an_o !== exp_an[s]) begin
                    errors++;
                    $display("FAIL load_mid_seq slot=%0d got nib %h an %b want nib %h an %b",
                             s, nib_o, an_o, exp_nib[s], exp_an[s]);
                end
                if (s == 3) done = 1'b1;
            end
        end
        load_i = 1'b0;
        checks++;
        if (upd_cnt != 1) begin
            errors++;
            $display("FAIL load_mid_upd count got %0d want 1", upd_cnt);
        end
    endtask

    task automatic test_lzb();
        logic seen = 1'b0;
        int s;
        for (int g = 0; g < 64 && (k % FRAME) != 20; g++) @(negedge clk);
        value_i = 16'h0005; dp_i = 4'b0010; lzb_i = 1'b1;
        for (int i = 0; i < 70; i++) begin
            load_i = (i == 0);
            @(negedge clk);
            checks++;
            if (obs !== expect_obs()) begin
                errors++;
                $display("FAIL lzb k=%0d got %h want %h", k, obs, expect_obs());
            end
            if (upd_o === 1'b1) seen = 1'b1;
            if (seen && (k % P) == B) begin
                s = (k / P) % 4;
                checks++;
                if (s == 0 && {an_o, nib_o, dp_o} !== {4'hE, 4'h5, 1'b1}) begin
                    errors++;
                    $display("FAIL lzb_digit0 got an %b nib %h dp %b want 1110 5 1", an_o, nib_o, dp_o);
                end else if (s != 0 && {an_o, dp_o} !== {4'hF, 1'b1}) begin
                    errors++;
                    $display("FAIL lzb_dark slot=%0d got an %b dp %b want 1111 1", s, an_o, dp_o);
                end
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_last_wins();
        int upd_cnt = 0;
        logic checked = 1'b0;
        for (int g = 0; g < 64 && (k % FRAME) != 3; g++) @(negedge clk);
        lzb_i = 1'b0; dp_i = 4'h0;
        for (int i = 0; i < 80; i++) begin
            load_i  = (i == 0) || (i == 8);
            value_i = (i < 8) ? 16'h1111 : 16'h2222;
            @(negedge clk);
            checks++;
            if (obs !== expect_obs()) begin
                errors++;
                $display("FAIL last_wins k=%0d got %h want %h", k, obs, expect_obs());
            end
            if (upd_o === 1'b1) upd_cnt++;
            if (upd_cnt == 1 && !checked && (k % FRAME) == B) begin
                checked = 1'b1;
                checks++;
                if (nib_o !== 4'h2) begin
                    errors++;
                    $display("FAIL last_wins_val got %h want 2", nib_o);
                end
            end
        end
        load_i = 1'b0;
        checks++;
        if (upd_cnt != 1) begin
            errors++;
            $display("FAIL last_wins_upd count got %0d want 1", upd_cnt);
        end
    endtask

    task automatic test_boundary();
        int base;
        int upd_k = -1;
        int upd_cnt = 0;
        for (int g = 0; g < 64 && (k % FRAME) != FRAME - 1; g++) @(negedge clk);
        base = k + 1;
        value_i = 16'hBEEF; dp_i = 4'b1000; lzb_i = 1'b0;
        for (int i = 0; i < 70; i++) begin
            load_i = (i == 0);
            @(negedge clk);
            checks++;
            if (obs !== expect_obs()) begin
                errors++;
                $display("FAIL boundary k=%0d got %h want %h", k, obs, expect_obs());
            end
            if (upd_o === 1'b1) begin upd_cnt++; upd_k = k; end
        end
        load_i = 1'b0;
        checks++;
        if (upd_cnt != 1 || upd_k != base + int'(FRAME)) begin
            errors++;
            $display("FAIL boundary_upd got count %0d at k=%0d want 1 at k=%0d", upd_cnt, upd_k, base + int'(FRAME));
        end
    endtask

    task automatic test_reset_mid();
        int upd_cnt = 0;
        for (int g = 0; g < 64 && (k % FRAME) != 13; g++) @(negedge clk);
        value_i = 16'($urandom) | 16'h0100; dp_i = 4'($urandom); lzb_i = 1'b0;
        for (int i = 0; i < 80; i++) begin
            load_i = (i == 0);
            rst    = (i == 1) || (i == 2);
            @(negedge clk);
            checks++;
            if (obs !== expect_obs()) begin
                errors++;
                $display("FAIL reset_mid k=%0d got %h want %h", k, obs, expect_obs());
            end
            if (i == 1) begin
                checks++;
                if (obs !== {4'hF, 1'b1, 4'h0, 2'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL reset_mid_vals got %h want %h", obs, {4'hF, 1'b1, 4'h0, 2'd0, 1'b0});
                end
            end
            if (i > 2 && upd_o === 1'b1) upd_cnt++;
        end
        load_i = 1'b0; rst = 1'b0;
        checks++;
        if (upd_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid_upd count got %0d want 0", upd_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 320; i++) begin
            load_i  = ($urandom_range(0, 11) == 0);
            value_i = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_i    = 4'($urandom);
            lzb_i   = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== expect_obs()) begin
                errors++;
                $display("FAIL random k=%0d got %h want %h", k, obs, expect_obs());
            end
        end
        load_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_mid();
        test_lzb();
        test_last_wins();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
